mdu_ex: RTL and testbench

Multiply/divide unit in the EX stage, directly upstream of the memory stage. It owns the HI/LO architectural registers and executes MULT, MULTU, DIV and DIVU as multi-cycle operations, plus the single-cycle MTHI and MTLO writes. It drives a busy flag that the hazard unit uses to stall MDU instructions and MFHI/MFLO in decode. HI/LO feed MFHI/MFLO results into the EX result mux, which flow on to `aluoutm`.

---
 rtl/mdu_ex_pkg.sv | 12 +
 rtl/mdu_ex.sv | 91 +++++++++
 tb/tb_mdu_ex.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mdu_ex_pkg.sv
// mdu_ex_pkg: op encodings, FSM states and default cycle counts shared by the MDU and the decoder
package mdu_ex_pkg;
  localparam logic [2:0] MDU_MULT = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV = 3'd2;
  localparam logic [2:0] MDU_DIVU = 3'd3;
  localparam logic [2:0] MDU_MTHI = 3'd4;
  localparam logic [2:0] MDU_MTLO = 3'd5;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic {IDLE, RUN} mdu_state_e;
endpackage

// File: rtl/mdu_ex.sv
// mdu_ex: EX-stage multiply/divide unit owning HI/LO, multi-cycle MULT/DIV and single-cycle MTHI/MTLO
// Ports: clk, reset (sync active-low), start/op/a/b issue an MDU op,
//        busy flags a multi-cycle op in flight, hi/lo are the architectural registers.
module mdu_ex
  import mdu_ex_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  mdu_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] op_q, op_n;
  logic [31:0] a_q, a_n, b_q, b_n, hi_n, lo_n;
  logic is_mul, is_div, ovf;
  logic [31:0] b_s, b_u;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  assign is_mul = op == MDU_MULT || op == MDU_MULTU;
  assign is_div = op == MDU_DIV || op == MDU_DIVU;
  // INT_MIN / -1 overflows; dividing by 1 instead yields the required lo=INT_MIN, hi=0
  assign ovf = a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF;
  assign b_s = (b_q == 32'd0 || ovf) ? 32'd1 : b_q;
  assign b_u = b_q == 32'd0 ? 32'd1 : b_q;
  assign prod_s = $signed(a_q) * $signed(b_q);
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign busy = state == RUN;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    op_n = op_q;
    a_n = a_q;
    b_n = b_q;
    hi_n = hi;
    lo_n = lo;
    if (state == IDLE && start) begin
      if (is_mul || is_div) begin
        state_n = RUN;
        cnt_n = is_mul ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
        op_n = op;
        a_n = a;
        b_n = b;
      end
      hi_n = op == MDU_MTHI ? a : hi;
      lo_n = op == MDU_MTLO ? a : lo;
    end else if (state == RUN) begin
      cnt_n = cnt - 4'd1;
      if (cnt == 4'd1) begin
        state_n = IDLE;
        // a zero divisor leaves HI/LO untouched
        if (op_q == MDU_MULT) {hi_n, lo_n} = prod_s;
        else if (op_q == MDU_MULTU) {hi_n, lo_n} = prod_u;
        else if (op_q == MDU_DIV && b_q != 32'd0) begin
          lo_n = $signed(a_q) / $signed(b_s);
          hi_n = $signed(a_q) % $signed(b_s);
        end else if (op_q == MDU_DIVU && b_q != 32'd0) begin
          lo_n = a_q / b_u;
          hi_n = a_q % b_u;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      op_q <= op_n;
      a_q <= a_n;
      b_q <= b_n;
      hi <= hi_n;
      lo <= lo_n;
    end
  end
endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex: self-checking bench for mdu_ex using a queue of expected {hi,lo} results
module tb_mdu_ex;
  import mdu_ex_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0, reset = 1, start = 0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_v;
  mdu_ex #(.MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  // called at a negedge; returns at the negedge of the cycle after the issue edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1;
    @(negedge clk);
  endtask
  task automatic test_mult;
    int n;
    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    exp_v = sb.pop_front();
    checks += 2;
    if (n !== MC) begin errors++; $display("FAIL mult_cycles got %0d want %0d", n, MC); end
    if ({hi, lo} !== exp_v) begin errors++; $display("FAIL mult_result got %h want %h", {hi, lo}, exp_v); end
    sb.push_back({32'h0000_0002, 32'hFFFF_FFFA});
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    exp_v = sb.pop_front();
    checks += 2;
    if (n !== MC) begin errors++; $display("FAIL multu_cycles got %0d want %0d", n, MC); end
    if ({hi, lo} !== exp_v) begin errors++; $display("FAIL multu_result got %h want %h", {hi, lo}, exp_v); end
  endtask
  task automatic test_div;
    int n;
    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    exp_v = sb.pop_front();
    checks += 2;
    if (n !== DC) begin errors++; $display("FAIL div_cycles got %0d want %0d", n, DC); end
    if ({hi, lo} !== exp_v) begin errors++; $display("FAIL div_result got %h want %h", {hi, lo}, exp_v); end
    sb.push_back({32'd1, 32'd3});
    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    exp_v = sb.pop_front();
    checks += 2;
    if (n !== DC) begin errors++; $display("FAIL divu_cycles got %0d want %0d", n, DC); end
    if ({hi, lo} !== exp_v) begin errors++; $display("FAIL divu_result got %h want %h", {hi, lo}, exp_v); end
  endtask
  task automatic test_div_edges;
    int n;
    issue(MDU_MTHI, 32'h11, 32'h0);
    checks += 2;
    if (hi !== 32'h11) begin errors++; $display("FAIL mthi got %h want 00000011", hi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b want 0", busy); end
    issue(MDU_MTLO, 32'h22, 32'h0);
    checks += 1;
    if (lo !== 32'h22) begin errors++; $display("FAIL mtlo got %h want 00000022", lo); end
    sb.push_back({32'h11, 32'h22});
    issue(MDU_DIV, 32'd1234, 32'd0);
    wait_idle(n);
    exp_v = sb.pop_front();
    checks += 2;
    if (n !== DC) begin errors++; $display("FAIL div0_cycles got %0d want %0d", n, DC); end
    if ({hi, lo} !== exp_v) begin errors++; $display("FAIL div0_result got %h want %h", {hi, lo}, exp_v); end
    sb.push_back({32'h0, 32'h8000_0000});
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    exp_v = sb.pop_front();
    checks += 2;
    if (n !== DC) begin errors++; $display("FAIL divovf_cycles got %0d want %0d", n, DC); end
    if ({hi, lo} !== exp_v) begin errors++; $display("FAIL divovf_result got %h want %h", {hi, lo}, exp_v); end
  endtask
  task automatic test_back_to_back;
    int n;
    sb.push_back({32'h0000_0001, 32'h2345_6780});
    issue(MDU_MULT, 32'h1234_5678, 32'h10);
    issue(MDU_MTLO, 32'h55, 32'h99);
    wait_idle(n);
    exp_v = sb.pop_front();
    checks += 2;
    if (n + 1 !== MC) begin errors++; $display("FAIL ign_cycles got %0d want %0d", n + 1, MC); end
    if ({hi, lo} !== exp_v) begin errors++; $display("FAIL ign_result got %h want %h", {hi, lo}, exp_v); end
    sb.push_back({32'h0, 32'h1});
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks += 1;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %0b want 1", busy); end
    wait_idle(n);
    exp_v = sb.pop_front();
    checks += 2;
    if (n !== MC) begin errors++; $display("FAIL b2b_cycles got %0d want %0d", n, MC); end
    if ({hi, lo} !== exp_v) begin errors++; $display("FAIL b2b_result got %h want %h", {hi, lo}, exp_v); end
  endtask
  task automatic test_reset_mid;
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
    if (hi !== 32'd0) begin errors++; $display("FAIL rmid_hi got %h want 0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL rmid_lo got %h want 0", lo); end
    repeat (DC + 2) @(negedge clk);
    checks += 2;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rmid_nowrite got %h want 0", {hi, lo}); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got %0b want 0", busy); end
  endtask
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edges();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
